// File: rtl/c7bifu_pkg.sv
// Shared definitions for the c7b IFU fetch front-end: reset PC, widths, queue-entry layout.
package c7bifu_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h1c00_0000;
  localparam int          PC_W           = 32;
  localparam int          INST_W         = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ibuf_entry_t;

  localparam int ENTRY_W = $bits(ibuf_entry_t);

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/c7bifu_ibuf.sv
// Synchronous FIFO with clear, occupancy count and zero-gated head output.
module c7bifu_ibuf
  import c7bifu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_dat_i,
  input  logic               pop_i,
  output logic [CW-1:0]      cnt_o,
  output logic               empty_o,
  output logic [ENTRY_W-1:0] head_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               do_push, do_pop;

  assign do_push = push_i & (cnt_q != CW'(DEPTH)) & ~clear_i;
  assign do_pop  = pop_i & (cnt_q != '0) & ~clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the head is gated to zero whenever the count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign cnt_o   = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/c7bifu_fetch.sv
// IFU fetch stage: credit-limited in-order fetch, response queue to decode,
// flush redirects the PC and discards every response still outstanding.
module c7bifu_fetch
  import c7bifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        ifu_icu_req,
  output logic [31:0] ifu_icu_addr,
  input  logic        icu_ifu_ack,
  input  logic        icu_ifu_rvld,
  input  logic [31:0] icu_ifu_rdata,
  output logic        inst_vld_f,
  output logic [31:0] inst_addr_f,
  output logic [31:0] inst_f
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic          started_q;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] q_cnt;
  logic          q_empty;
  logic [ENTRY_W-1:0] q_head;
  ibuf_entry_t   head_s;
  logic          credit_ok, hs, keep, pop;

  // Queue slots plus outstanding requests never exceed the queue depth, so rvld needs no backpressure.
  assign credit_ok    = ({1'b0, q_cnt} + {1'b0, inflight_q}) < (CW+1)'(QDEPTH);
  assign ifu_icu_req  = started_q & ~flush & credit_ok;
  assign ifu_icu_addr = pc_q;
  assign hs           = ifu_icu_req & icu_ifu_ack;
  assign keep         = icu_ifu_rvld & (drop_q == '0) & ~flush;
  assign pop          = inst_vld_f & ~stall & ~flush;

  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CW'(hs) - CW'(icu_ifu_rvld);
    if (flush) begin
      pc_d      = align_pc(redirect_pc);
      resp_pc_d = align_pc(redirect_pc);
      drop_d    = inflight_d;
    end else begin
      if (hs) pc_d = pc_q + 32'd4;
      if (icu_ifu_rvld) begin
        if (drop_q != '0) drop_d = drop_q - CW'(1);
        else              resp_pc_d = resp_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      started_q  <= 1'b0;
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      started_q  <= 1'b1;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  c7bifu_ibuf #(.DEPTH(QDEPTH)) u_ibuf (
    .clk        (clk),
    .resetn     (resetn),
    .clear_i    (flush),
    .push_i     (keep),
    .push_dat_i ({resp_pc_q, icu_ifu_rdata}),
    .pop_i      (pop),
    .cnt_o      (q_cnt),
    .empty_o    (q_empty),
    .head_o     (q_head)
  );

  assign head_s      = q_head;
  assign inst_vld_f  = ~q_empty;
  assign inst_addr_f = head_s.pc;
  assign inst_f      = head_s.inst;

  rvld_needs_inflight: assert property (@(posedge clk) disable iff (!resetn)
    icu_ifu_rvld |-> (inflight_q != '0));

endmodule
